pwm_capture: RTL

PWM decoder that measures an incoming pulse-width-modulated signal, such as one produced by the team's `pwm` generator. Each period runs from one rising edge to the next. For every complete period, the block reports the period length and the high time, both counted in `step` ticks. A line held constant (duty 0 or full-on) is reported as stuck, together with its level. It sits on the input side of the etch-a-sketch design, for example on servo or feedback lines, feeding the control logic.

---
 rtl/pwm_capture.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of a PWM input in step ticks,
// and reports a stuck line when no edge arrives for 2^M-1 steps.
module pwm_capture #(
  parameter int unsigned N = 8,
  parameter int unsigned M = N + 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         step,
  input  logic         pwm_in,
  output logic [M-1:0] period,
  output logic [M-1:0] high_count,
  output logic         valid,
  output logic         stuck,
  output logic         level
);

  localparam logic [M-1:0] CNT_MAX = '1;
  localparam logic [M-1:0] CNT_ONE = M'(1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MEASURE = 1'b1
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [M-1:0] pcnt_q;
  logic [M-1:0] pcnt_d;
  logic [M-1:0] hcnt_q;
  logic [M-1:0] hcnt_d;
  logic [M-1:0] period_d;
  logic [M-1:0] high_d;
  logic         valid_d;
  logic         stuck_d;
  logic         level_d;

  logic sync_meta;
  logic sync;
  logic smp;
  logic rise_c;

  // Two-flop synchronizer, free running regardless of ena/step
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= pwm_in;
      sync      <= sync_meta;
    end
  end

  // Sample register advances only on step cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      smp <= 1'b0;
    end else if (step) begin
      smp <= sync;
    end
  end

  assign rise_c = step & sync & ~smp;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pcnt_q     <= '0;
      hcnt_q     <= '0;
      period     <= '0;
      high_count <= '0;
      valid      <= 1'b0;
      stuck      <= 1'b0;
      level      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      hcnt_q     <= hcnt_d;
      period     <= period_d;
      high_count <= high_d;
      valid      <= valid_d;
      stuck      <= stuck_d;
      level      <= level_d;
    end
  end

  // Next-state, counter and report logic; counters are checked before incrementing so they never wrap
  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    hcnt_d   = hcnt_q;
    period_d = period;
    high_d   = high_count;
    valid_d  = 1'b0;
    stuck_d  = stuck;
    level_d  = level;

    if (!ena) begin
      state_d = S_IDLE;
      pcnt_d  = '0;
      hcnt_d  = '0;
    end else if (step) begin
      case (state_q)
        S_IDLE: begin
          if (rise_c) begin
            pcnt_d  = CNT_ONE;
            hcnt_d  = CNT_ONE;
            state_d = S_MEASURE;
          end else if (sync != smp) begin
            pcnt_d = '0;
          end else if (pcnt_q == CNT_MAX) begin
            // Report only a new stuck condition; otherwise stay saturated
            if (!stuck || (level != sync)) begin
              stuck_d  = 1'b1;
              level_d  = sync;
              period_d = '0;
              high_d   = '0;
              valid_d  = 1'b1;
              pcnt_d   = '0;
            end
          end else begin
            pcnt_d = pcnt_q + CNT_ONE;
          end
        end
        S_MEASURE: begin
          if (rise_c) begin
            period_d = pcnt_q;
            high_d   = hcnt_q;
            stuck_d  = 1'b0;
            valid_d  = 1'b1;
            pcnt_d   = CNT_ONE;
            hcnt_d   = CNT_ONE;
          end else if (pcnt_q == CNT_MAX) begin
            stuck_d  = 1'b1;
            level_d  = sync;
            period_d = '0;
            high_d   = '0;
            valid_d  = 1'b1;
            pcnt_d   = '0;
            hcnt_d   = '0;
            state_d  = S_IDLE;
          end else begin
            pcnt_d = pcnt_q + CNT_ONE;
            hcnt_d = hcnt_q + M'(sync);
          end
        end
        default: begin
          state_d = S_IDLE;
          pcnt_d  = '0;
          hcnt_d  = '0;
        end
      endcase
    end
  end

endmodule
